fifo_d_salida: RTL
==================

Name: fifo_d_salida

Overview:
- Output-side FIFO directly downstream of the VC arbiter: one instance per destination, D0 and D1.
- Accepts 6-bit words when the arbiter asserts D0_push/D1_push.
- Returns back-pressure to the arbiter through the pause output, which drives D0_pause/D1_pause.
- The consumer stage drains it through pop.

Parameters:
DATA_WIDTH, 6, word width (matches arbiter output bus)
ADDR_WIDTH, 2, pointer width; DEPTH = 2**ADDR_WIDTH = 4 entries
ALMOST_FULL, 3, occupancy at or above which pause asserts (1..DEPTH)
ALMOST_EMPTY, 1, occupancy at or below which almost_empty asserts (0..DEPTH-1)

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous reset, active-high
data_in  input  DATA_WIDTH  word from arbiter
push  input  1  write data_in this cycle
pop  input  1  read request from consumer
data_out  output  DATA_WIDTH  registered read data
valid_out  output  1  data_out holds a word popped on the previous edge
full  output  1  occupancy == DEPTH
empty  output  1  occupancy == 0
pause  output  1  occupancy >= ALMOST_FULL; feeds arbiter Dx_pause
almost_empty  output  1  occupancy <= ALMOST_EMPTY
error  output  1  sticky overflow/underflow flag

Behaviour:
- Reset is synchronous and active-high: sampled only on the rising clk edge.
- Reset values: wr_ptr = 0, rd_ptr = 0, count = 0, data_out = 0, valid_out = 0, error = 0, full = 0, pause = 0, empty = 1, almost_empty = 1. Memory contents are don't-care.
- Reset takes priority over push/pop in the same cycle; an in-flight word is discarded.
- State: wr_ptr and rd_ptr (ADDR_WIDTH bits, wrap modulo DEPTH) and count (ADDR_WIDTH+1 bits).
- Flags are combinational from count, so pause reflects occupancy in the same cycle it changes. The arbiter samples pause one edge later, so the ALMOST_FULL default leaves 1 entry of slack.
- Write acceptance: push && (!full || pop_ok).
  - On acceptance, mem[wr_ptr] <= data_in and wr_ptr increments.
- Read acceptance: pop_ok = pop && !empty.
  - On acceptance, data_out <= mem[rd_ptr], rd_ptr increments and valid_out <= 1.
  - Otherwise valid_out <= 0 and data_out holds its value.
- Read latency: 1 cycle from pop to data_out/valid_out.
- Count: +1 on an accepted write alone, -1 on an accepted read alone, unchanged when both are accepted.
- Full with push && pop: both are accepted, count stays DEPTH, and the slot freed by the read is the one written.
- Empty with push && pop: no bypass. The write is accepted, the read is rejected, and error is set.
- Overflow (push && full && !pop): the word is dropped, pointers are unchanged, and error <= 1.
- Underflow (pop && empty): no pointer change, valid_out <= 0, error <= 1.
- error stays 1 until reset.
- Pointer wrap: 3 -> 0 with no special handling; count alone disambiguates full from empty.

Decomposition:
- Shared package fifo_pkg:
  - DATA_WIDTH = 6.
  - Default DEPTH/ADDR_WIDTH.
  - Default thresholds.
  - Arbiter/FIFO instances reference these same constants.
- One sub-module, fifo_mem: a DEPTH x DATA_WIDTH register file with a synchronous write port and an asynchronous read port.
- fifo_d_salida holds the pointers, counter, flags, output register and error logic.

Test Plan:
- Reset: hold reset = 1 for 2 edges -> empty = 1, almost_empty = 1, full = 0, pause = 0, error = 0, data_out = 0, valid_out = 0.
- Fill: push 6'h34, 6'h36, 6'h25 on consecutive edges.
  - After the 3rd edge: count = 3, pause = 1, full = 0.
  - A 4th push of 6'h2C gives full = 1.
- Drain order: pop 4 times -> data_out = 6'h34, 6'h36, 6'h25, 6'h2C on the edges following each pop, with valid_out = 1 each cycle.
  - Then empty = 1 and pause = 0.
- Overflow: with full = 1, push 6'h3D without pop -> error = 1, count stays 4. Draining then yields the original 4 words, not 6'h3D.
- Full push+pop:
  - Fill with 6'h01..6'h04, then push 6'h05 with pop in the same cycle -> data_out = 6'h01, full stays 1.
  - Draining yields 6'h02..6'h05, exercising pointer wrap.
- Empty push+pop and mid-operation reset:
  - From empty, push 6'h16 with pop -> valid_out = 0, error = 1, count = 1.
  - Then assert reset with push high -> count = 0, error = 0, empty = 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants for the per-destination output FIFOs and the VC arbiter that feeds them.
// Default geometry is 4 x 6-bit; pause threshold leaves one entry of slack.
package fifo_pkg;
   localparam int DATA_WIDTH   = 6;
   localparam int ADDR_WIDTH   = 2;
   localparam int DEPTH        = 1 << ADDR_WIDTH;
   localparam int ALMOST_FULL  = 3;
   localparam int ALMOST_EMPTY = 1;

   typedef struct packed {
      logic full;
      logic empty;
      logic pause;
      logic almost_empty;
   } fifo_flags_t;
endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register file: synchronous write, asynchronous read.
// No reset; contents are only observed after being written.
module fifo_mem #(
   parameter int DATA_WIDTH = 6,
   parameter int ADDR_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_dat_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_dat_o
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_dat_i;
      end
   end

   assign rd_dat_o = mem_q[rd_addr_i];
endmodule

// File: rtl/fifo_d_salida.sv
// Output FIFO per destination: 1-cycle pop-to-data latency, registered data_out/valid_out.
// Back-pressure via combinational pause (occupancy >= ALMOST_FULL); overflow/underflow set sticky error.
module fifo_d_salida
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH   = fifo_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH   = fifo_pkg::ADDR_WIDTH,
   parameter int ALMOST_FULL  = fifo_pkg::ALMOST_FULL,
   parameter int ALMOST_EMPTY = fifo_pkg::ALMOST_EMPTY
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  push,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic                  full,
   output logic                  empty,
   output logic                  pause,
   output logic                  almost_empty,
   output logic                  error
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int CW    = ADDR_WIDTH + 1;

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d, rd_dat;
   logic                  valid_q, valid_d, error_q, error_d;
   logic                  wr_ok, rd_ok;
   fifo_flags_t           flags;

   always_comb begin
      flags.full         = (count_q == CW'(DEPTH));
      flags.empty        = (count_q == '0);
      flags.pause        = (count_q >= CW'(ALMOST_FULL));
      flags.almost_empty = (count_q <= CW'(ALMOST_EMPTY));
   end

   // A full FIFO still takes a write when a read frees a slot in the same cycle.
   assign rd_ok = pop && !flags.empty;
   assign wr_ok = push && (!flags.full || rd_ok);

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk       (clk),
      .wr_en_i   (wr_ok),
      .wr_addr_i (wr_ptr_q),
      .wr_dat_i  (data_in),
      .rd_addr_i (rd_ptr_q),
      .rd_dat_o  (rd_dat)
   );

   always_comb begin
      wr_ptr_d   = wr_ok ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
      rd_ptr_d   = rd_ok ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
      data_out_d = rd_ok ? rd_dat : data_out_q;
      valid_d    = rd_ok;
      error_d    = error_q | (push && flags.full && !pop) | (pop && flags.empty);
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         data_out_q <= '0;
         valid_q    <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         data_out_q <= data_out_d;
         valid_q    <= valid_d;
         error_q    <= error_d;
      end
   end

   assign data_out     = data_out_q;
   assign valid_out    = valid_q;
   assign full         = flags.full;
   assign empty        = flags.empty;
   assign pause        = flags.pause;
   assign almost_empty = flags.almost_empty;
   assign error        = error_q;
endmodule
